// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; decode imports the same NOP for its flushes.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h0000_0004;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instruction addresses are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage, instruction memory, execute redirect and the IF/ID consumer.
interface fetch_unit_if;

  logic [31:0] im_rd_ads;
  logic [31:0] ist;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output im_rd_ads,
    input  ist,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_instr,
    output if_pc,
    output if_pc_plus4
  );

  modport slave (
    input  im_rd_ads,
    output ist,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word with its PC, flushes to an invalid NOP, else holds.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  // Flush wins over load so a redirect always discards the word fetched alongside it.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = ld_instr;
      pc_d       = ld_pc;
      pc_plus4_d = ld_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the zero-latency instruction memory and fills IF/ID,
// with stall on decode back-pressure, redirect from execute and halt on an all-zero word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_unit_if.master     bus,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  import fetch_pkg::*;

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, flush, accept;

  assign accept        = !bus.if_valid || bus.id_ready;
  assign bus.im_rd_ads = pc_q;

  // Redirect overrides everything, including a stall and a halt.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    flush    = 1'b0;
    if (bus.redirect_valid) begin
      pc_d     = align_pc(bus.redirect_pc);
      flush    = 1'b1;
      halted_d = 1'b0;
      state_d  = FETCH;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: begin
          if (accept) begin
            if (bus.ist != 32'h0) begin
              load = 1'b1;
              pc_d = pc_q + 32'd4;
              if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end else begin
              flush    = 1'b1;
              halted_d = 1'b1;
              state_d  = HALT;
            end
          end
        end
        HALT:    if (bus.id_ready) flush = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (flush),
    .ld_instr (bus.ist),
    .ld_pc    (pc_q),
    .valid    (bus.if_valid),
    .instr    (bus.if_instr),
    .pc       (bus.if_pc),
    .pc_plus4 (bus.if_pc_plus4)
  );

  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule
